// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file for the nlp16 core.
// Two byte-strobed write ports, post-reset clear sequencer, optional bypass.
module reg_file_mp #(
    parameter int DATA_W = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD = 3,
    parameter int BYPASS = 1,
    parameter int ZR_IDX = 15,
    parameter int MEM_IDX = 14,
    parameter int IR1_IDX = 12,
    parameter int IR2_IDX = 13,
    parameter logic [DATA_W-1:0] IR2_MASK = DATA_W'('h00FF),
    localparam int AW = $clog2(NUM_REGS),
    localparam int NB = DATA_W / 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wa_en,
    input  logic [AW-1:0]            i_wa_addr,
    input  logic [NB-1:0]            i_wa_be,
    input  logic [DATA_W-1:0]        i_wa_data,
    input  logic                     i_wb_en,
    input  logic [AW-1:0]            i_wb_addr,
    input  logic [NB-1:0]            i_wb_be,
    input  logic [DATA_W-1:0]        i_wb_data,
    input  logic [NUM_RD*AW-1:0]     i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0]        o_ir1,
    output logic [DATA_W-1:0]        o_ir2,
    output logic                     o_ready,
    output logic                     o_wr_conflict
);

    localparam logic [AW-1:0] ZR_A = AW'(ZR_IDX);
    localparam logic [AW-1:0] MEM_A = AW'(MEM_IDX);
    localparam logic [AW-1:0] IR1_A = AW'(IR1_IDX);
    localparam logic [AW-1:0] IR2_A = AW'(IR2_IDX);
    localparam logic [AW-1:0] LAST_A = AW'(NUM_REGS - 1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              ready;
    logic [NB-1:0]     a_lane;
    logic [NB-1:0]     b_lane;
    logic              conf_d;

    function automatic logic is_dead(input logic [AW-1:0] a);
        return (a == ZR_A) || (a == MEM_A);
    endfunction

    assign ready = (state == S_READY);
    assign o_ready = ready;

    // Lane write enables after gating and the A-over-B priority merge
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        if (ready && !i_rst) begin
            if (i_wa_en && !is_dead(i_wa_addr)) a_lane = i_wa_be;
            if (i_wb_en && !is_dead(i_wb_addr)) b_lane = i_wb_be;
            if (i_wb_addr == i_wa_addr) b_lane = b_lane & ~a_lane;
        end
    end

    // Overlapping-strobe collision on a real register
    always_comb begin
        conf_d = ready && i_wa_en && i_wb_en &&
                 (i_wa_addr == i_wb_addr) &&
                 ((i_wa_be & i_wb_be) != '0) &&
                 !is_dead(i_wa_addr);
    end

    // Clear sequencer FSM and registered conflict flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_CLEAR;
            clr_cnt <= '0;
            o_wr_conflict <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    o_wr_conflict <= 1'b0;
                    if (clr_cnt == LAST_A) state <= S_READY;
                end
                S_READY: begin
                    o_wr_conflict <= conf_d;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Storage: zero one entry per clear cycle, else merged lane writes
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == S_CLEAR) begin
                regs[clr_cnt] <= '0;
            end else begin
                for (int j = 0; j < NB; j++) begin
                    if (a_lane[j])
                        regs[i_wa_addr][j*8 +: 8] <= i_wa_data[j*8 +: 8];
                    if (b_lane[j])
                        regs[i_wb_addr][j*8 +: 8] <= i_wb_data[j*8 +: 8];
                end
            end
        end
    end

    // Instruction-register taps show stored contents once cleared
    always_comb begin
        o_ir1 = ready ? regs[IR1_A] : '0;
        o_ir2 = ready ? regs[IR2_A] : '0;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] v;

        assign ra = i_rd_addr[k*AW +: AW];

        // Stored value, optionally overlaid by this cycle's writes, then masked
        always_comb begin
            v = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NB; j++) begin
                    if (b_lane[j] && (i_wb_addr == ra))
                        v[j*8 +: 8] = i_wb_data[j*8 +: 8];
                    if (a_lane[j] && (i_wa_addr == ra))
                        v[j*8 +: 8] = i_wa_data[j*8 +: 8];
                end
            end
            if (is_dead(ra) || !ready) v = '0;
            if (ra == IR2_A) v = v & IR2_MASK;
        end

        assign o_rd_data[k*DATA_W +: DATA_W] = v;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: three configurations driven from shared stimulus
// (16b bypass, 16b no bypass, 32b x 32 regs x 4 ports) against a model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wa_en, wb_en;
    logic [4:0]  wa_addr, wb_addr;
    logic [3:0]  wa_be, wb_be;
    logic [31:0] wa_data, wb_data;
    logic [4:0]  rda [4];
    logic [11:0] rd_addr16;
    logic [19:0] rd_addr32;

    assign rd_addr16 = {rda[2][3:0], rda[1][3:0], rda[0][3:0]};
    assign rd_addr32 = {rda[3], rda[2], rda[1], rda[0]};

    logic [47:0]  rd0, rd1;
    logic [127:0] rd2;
    logic [15:0]  ir1_0, ir2_0, ir1_1, ir2_1;
    logic [31:0]  ir1_2, ir2_2;
    logic         rdy0, rdy1, rdy2, cf0, cf1, cf2;

    reg_file_mp #(.BYPASS(1)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr[3:0]),
        .i_wa_be(wa_be[1:0]), .i_wa_data(wa_data[15:0]),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr[3:0]),
        .i_wb_be(wb_be[1:0]), .i_wb_data(wb_data[15:0]),
        .i_rd_addr(rd_addr16), .o_rd_data(rd0),
        .o_ir1(ir1_0), .o_ir2(ir2_0),
        .o_ready(rdy0), .o_wr_conflict(cf0)
    );

    reg_file_mp #(.BYPASS(0)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr[3:0]),
        .i_wa_be(wa_be[1:0]), .i_wa_data(wa_data[15:0]),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr[3:0]),
        .i_wb_be(wb_be[1:0]), .i_wb_data(wb_data[15:0]),
        .i_rd_addr(rd_addr16), .o_rd_data(rd1),
        .o_ir1(ir1_1), .o_ir2(ir2_1),
        .o_ready(rdy1), .o_wr_conflict(cf1)
    );

    reg_file_mp #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .BYPASS(1),
        .IR2_MASK(32'h0000_00FF)
    ) u2 (
        .i_clk(clk), .i_rst(rst),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr),
        .i_wa_be(wa_be), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr),
        .i_wb_be(wb_be), .i_wb_data(wb_data),
        .i_rd_addr(rd_addr32), .o_rd_data(rd2),
        .o_ir1(ir1_2), .o_ir2(ir2_2),
        .o_ready(rdy2), .o_wr_conflict(cf2)
    );

    logic [31:0] mem [3][32];
    int          clr [3];
    bit          mrdy [3];
    bit          mconf [3];
    int          checks = 0;
    int          errors = 0;

    function automatic int nregs(int c);
        return (c == 2) ? 32 : 16;
    endfunction

    function automatic int nrd(int c);
        return (c == 2) ? 4 : 3;
    endfunction

    function automatic logic [31:0] dmask(int c);
        return (c == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [4:0] amask(int c);
        return (c == 2) ? 5'h1F : 5'h0F;
    endfunction

    function automatic logic [3:0] bmask(int c);
        return (c == 2) ? 4'hF : 4'h3;
    endfunction

    function automatic bit dead(logic [4:0] a);
        return (a == 5'd14) || (a == 5'd15);
    endfunction

    // Expected read: writes pending this cycle land B first, then A on top
    function automatic logic [31:0] exp_rd(int c, logic [4:0] ra);
        logic [4:0]  a;
        logic [3:0]  lb;
        logic [31:0] v;
        a = ra & amask(c);
        lb = bmask(c);
        if (!mrdy[c] || dead(a)) return 32'h0;
        v = mem[c][a];
        if (c != 1 && !rst) begin
            for (int j = 0; j < 4; j++) begin
                if (wb_en && (wb_addr & amask(c)) == a && wb_be[j] && lb[j])
                    v[j*8 +: 8] = wb_data[j*8 +: 8];
            end
            for (int j = 0; j < 4; j++) begin
                if (wa_en && (wa_addr & amask(c)) == a && wa_be[j] && lb[j])
                    v[j*8 +: 8] = wa_data[j*8 +: 8];
            end
        end
        if (a == 5'd13) v = v & 32'h0000_00FF;
        return v & dmask(c);
    endfunction

    function automatic logic [31:0] obs_rd(int c, int k);
        if (c == 0) return 32'(rd0[k*16 +: 16]);
        if (c == 1) return 32'(rd1[k*16 +: 16]);
        return rd2[k*32 +: 32];
    endfunction

    function automatic logic [31:0] obs_ir(int c, int n);
        if (c == 0) return 32'((n == 1) ? ir1_0 : ir2_0);
        if (c == 1) return 32'((n == 1) ? ir1_1 : ir2_1);
        return (n == 1) ? ir1_2 : ir2_2;
    endfunction

    function automatic logic obs_rdy(int c);
        return (c == 0) ? rdy0 : (c == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic obs_cf(int c);
        return (c == 0) ? cf0 : (c == 1) ? cf1 : cf2;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model state advance at a rising edge, using inputs held across it
    task automatic upd();
        logic [4:0] a, b;
        logic [3:0] lb;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                mrdy[c] = 1'b0;
                clr[c] = nregs(c);
                mconf[c] = 1'b0;
            end else if (!mrdy[c]) begin
                mconf[c] = 1'b0;
                clr[c]--;
                if (clr[c] == 0) begin
                    mrdy[c] = 1'b1;
                    for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
                end
            end else begin
                a = wa_addr & amask(c);
                b = wb_addr & amask(c);
                lb = bmask(c);
                mconf[c] = wa_en && wb_en && (a == b) &&
                           ((wa_be & wb_be & lb) != 4'h0) && !dead(a);
                if (wb_en && !dead(b))
                    for (int j = 0; j < 4; j++)
                        if (wb_be[j] && lb[j])
                            mem[c][b][j*8 +: 8] = wb_data[j*8 +: 8];
                if (wa_en && !dead(a))
                    for (int j = 0; j < 4; j++)
                        if (wa_be[j] && lb[j])
                            mem[c][a][j*8 +: 8] = wa_data[j*8 +: 8];
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] e1, e2;
        for (int c = 0; c < 3; c++) begin
            e1 = mrdy[c] ? (mem[c][12] & dmask(c)) : 32'h0;
            e2 = mrdy[c] ? (mem[c][13] & dmask(c)) : 32'h0;
            chk($sformatf("c%0d_ready", c), 32'(obs_rdy(c)), 32'(mrdy[c]));
            chk($sformatf("c%0d_conflict", c), 32'(obs_cf(c)), 32'(mconf[c]));
            chk($sformatf("c%0d_ir1", c), obs_ir(c, 1), e1);
            chk($sformatf("c%0d_ir2", c), obs_ir(c, 2), e2);
            for (int k = 0; k < nrd(c); k++)
                chk($sformatf("c%0d_rd%0d_a%0d", c, k, rda[k] & amask(c)),
                    obs_rd(c, k), exp_rd(c, rda[k]));
        end
    endtask

    task automatic cycle();
        #2 check_all();
        @(posedge clk);
        upd();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wa_en = 1'b0; wb_en = 1'b0;
        wa_be = 4'h0; wb_be = 4'h0;
        wa_addr = 5'd0; wb_addr = 5'd0;
        wa_data = 32'h0; wb_data = 32'h0;
    endtask

    initial begin
        idle();
        for (int k = 0; k < 4; k++) rda[k] = 5'd0;
        rst = 1'b1;
        @(posedge clk);
        upd();
        #1;
        cycle();
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            cycle();
            chk("clr_lat16", 32'(rdy0), 32'(i >= 16));
            chk("clr_lat32", 32'(rdy2), 32'(i >= 32));
        end

        wa_en = 1'b1; wa_addr = 5'd3; wa_be = 4'hF; wa_data = 32'h0000_BEEF;
        rda[0] = 5'd3;
        cycle();
        idle();
        cycle();
        chk("preload3", 32'(rd1[15:0]), 32'h0000_BEEF);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            cycle();
            chk("reclr_lat16", 32'(rdy0), 32'(i >= 16));
        end
        chk("reg3_cleared", 32'(rd0[15:0]), 32'h0);

        wa_en = 1'b1; wa_addr = 5'd2; wa_be = 4'hF; wa_data = 32'h0000_1234;
        cycle();
        wa_be = 4'h1; wa_data = 32'h0000_AAFF;
        cycle();
        idle();
        rda[0] = 5'd2;
        cycle();
        chk("byte_strobe", 32'(rd1[15:0]), 32'h0000_12FF);

        wa_en = 1'b1; wa_addr = 5'd5; wa_be = 4'h1; wa_data = 32'h0000_00AA;
        wb_en = 1'b1; wb_addr = 5'd5; wb_be = 4'h3; wb_data = 32'h0000_5555;
        rda[1] = 5'd5;
        #2 chk("coll_bypass", 32'(rd0[31:16]), 32'h0000_55AA);
        cycle();
        idle();
        chk("coll_conf", 32'(cf0), 32'h1);
        chk("coll_value", 32'(rd1[31:16]), 32'h0000_55AA);
        cycle();
        chk("coll_conf_clr", 32'(cf0), 32'h0);

        wa_en = 1'b1; wa_addr = 5'd15; wa_be = 4'hF; wa_data = 32'hFFFF_FFFF;
        wb_en = 1'b1; wb_addr = 5'd14; wb_be = 4'hF; wb_data = 32'hFFFF_FFFF;
        rda[0] = 5'd15; rda[1] = 5'd14;
        cycle();
        idle();
        cycle();
        chk("zr_read", 32'(rd0[15:0]), 32'h0);
        chk("mem_read", 32'(rd0[31:16]), 32'h0);

        wa_en = 1'b1; wa_addr = 5'd13; wa_be = 4'hF; wa_data = 32'h0000_ABCD;
        rda[2] = 5'd13;
        cycle();
        idle();
        cycle();
        chk("ir2_masked_rd", 32'(rd0[47:32]), 32'h0000_00CD);
        chk("ir2_tap", 32'(ir2_0), 32'h0000_ABCD);
        chk("ir2_tap32", ir2_2, 32'h0000_ABCD);

        wa_en = 1'b1; wa_addr = 5'd7; wa_be = 4'hF; wa_data = 32'h0000_1111;
        rda[2] = 5'd7;
        cycle();
        wa_data = 32'h0000_4321;
        #2 chk("bypass1_same", 32'(rd0[47:32]), 32'h0000_4321);
        chk("bypass0_old", 32'(rd1[47:32]), 32'h0000_1111);
        cycle();
        idle();
        chk("bypass0_next", 32'(rd1[47:32]), 32'h0000_4321);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            wa_en = 1'($urandom_range(0, 1));
            wb_en = 1'($urandom_range(0, 1));
            wa_addr = 5'($urandom_range(0, 31));
            wb_addr = ($urandom_range(0, 2) == 0) ? wa_addr
                                                  : 5'($urandom_range(0, 31));
            wa_be = 4'($urandom_range(0, 15));
            wb_be = 4'($urandom_range(0, 15));
            wa_data = $urandom;
            wb_data = $urandom;
            for (int k = 0; k < 4; k++)
                rda[k] = ($urandom_range(0, 1) == 0) ? wa_addr
                                                     : 5'($urandom_range(0, 31));
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the nlp16 datapath core, replacing the fixed 16×16 three-read/one-write file.
- Generalised width, depth and read-port count.
- Two write ports (ALU result, load return) with byte strobes and a fixed priority rule.
- Hardware clear sequencer after reset.
- Optional write-to-read bypass.
- Parametrised hard-zero and masked-read register indices; instruction-register taps.

## Interface
Parameters:
- DATA_W, 16: register width; multiple of 8.
- NUM_REGS, 16: register count; power of two ≥ 4; AW = $clog2(NUM_REGS).
- NUM_RD, 3: number of combinational read ports.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- ZR_IDX, 15: reads as zero; writes dropped.
- MEM_IDX, 14: reads as zero; writes dropped.
- IR1_IDX, 12: tapped to o_ir1.
- IR2_IDX, 13: tapped to o_ir2; masked on read ports.
- IR2_MASK, 16'h00FF: AND mask applied to IR2_IDX on read ports; width DATA_W.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wa_en  in  1  write port A enable (ALU).
- i_wa_addr  in  AW  port A address.
- i_wa_be  in  DATA_W/8  port A byte strobes.
- i_wa_data  in  DATA_W  port A data.
- i_wb_en / i_wb_addr / i_wb_be / i_wb_data  in  1 / AW / DATA_W/8 / DATA_W  write port B (load return); same meaning as port A.
- i_rd_addr  in  NUM_RD*AW  packed read addresses; port k = bits [k*AW +: AW].
- o_rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W].
- o_ir1  out  DATA_W  stored contents of IR1_IDX, unmasked, never bypassed.
- o_ir2  out  DATA_W  stored contents of IR2_IDX, unmasked, never bypassed.
- o_ready  out  1  1 = clear sequence complete; writes accepted.
- o_wr_conflict  out  1  registered one-cycle pulse: A and B wrote the same address with overlapping strobes.

## Operation
- State machine: CLEAR → READY.
  - i_rst forces CLEAR with clear counter = 0, from either state and at any point mid-clear.
  - In CLEAR, register[counter] is written to 0 each cycle and the counter increments. After index NUM_REGS-1 is written, the next state is READY.
  - READY holds until i_rst.
- During CLEAR:
  - o_ready = 0.
  - Port A and port B writes are ignored, with no effect on o_wr_conflict.
  - All read ports, o_ir1 and o_ir2 return 0.
- Write, per byte lane j:
  - Lane j of register addr is updated when en & be[j] and the state is READY.
  - Lanes with be[j] = 0 hold their value.
  - Writes to ZR_IDX or MEM_IDX are discarded.
- Collision (both enabled, same address): port A wins on each lane where wa_be[j] = 1. Port B writes only the lanes where wa_be[j] = 0 and wb_be[j] = 1.
- o_wr_conflict is set on the next edge iff READY & both enabled & same address & (wa_be & wb_be) ≠ 0 & the address is not ZR_IDX or MEM_IDX. It clears on the following edge unless re-triggered.
- Read port k (combinational):
  - ZR_IDX or MEM_IDX → 0.
  - Otherwise, value = stored register.
  - If BYPASS = 1, lanes being written this cycle (after the A/B priority merge) replace the stored lanes.
  - If the address is IR2_IDX, value & IR2_MASK.
- o_ir1 / o_ir2: raw stored values; they reflect a write one cycle after it.

## Timing
- Reset values:
  - o_ready = 0.
  - o_wr_conflict = 0.
  - o_ir1 = o_ir2 = 0, and all read data = 0, while CLEAR.
- Clear latency: i_rst deasserted at edge T → o_ready = 1 after edge T + NUM_REGS (16 cycles with defaults).
- Write latency: data presented at edge T is stored and visible to BYPASS = 0 reads and to IR taps after edge T.
- BYPASS = 1: read reflects the write in the same cycle, before the edge.
- Read ports have no clock latency; no handshake.

## Test plan
- Reset clear: preload reg 3 = 16'hBEEF, pulse i_rst → o_ready low for 16 cycles, then high; reg 3 reads 0. Re-assert i_rst at clear cycle 5 → counter restarts and o_ready rises 16 cycles after the final deassert.
- Byte strobes: write reg 2 = 16'h1234, then port A be = 2'b01 with data 16'hAAFF → reg 2 = 16'h12FF.
- Collision: A writes reg 5 be 01 data 16'h00AA; B writes reg 5 be 11 data 16'h5555 → reg 5 = 16'h55AA; o_wr_conflict = 1 for exactly the next cycle.
- Special indices: write 16'hFFFF to 15 and 14 → all reads return 0. Write 16'hABCD to 13 → read port returns 16'h00CD; o_ir2 = 16'hABCD.
- Bypass: BYPASS = 1, write reg 7 = 16'h4321 with read port 2 on reg 7 → 16'h4321 in the same cycle. BYPASS = 0 → old value in the write cycle, 16'h4321 the next cycle.
- Parametrisation: DATA_W = 32, NUM_REGS = 32, NUM_RD = 4 → clear takes 32 cycles; random writes and reads match a reference model.
